// File: rtl/exec_sequencer_if.sv
// Bus bundle between the execute sequencer and its fetcher, memory and ALU.
// The sequencer takes the slave side; the environment drives the master side.
interface exec_sequencer_if;
    logic        instruction_ready;
    logic [7:0]  opcode;
    logic [15:0] op_addr;
    logic [7:0]  imm;
    logic [15:0] pc;
    logic [7:0]  acc;
    logic [7:0]  flags;
    logic [7:0]  data_in;
    logic        alu_done;
    logic [7:0]  alu_result;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic        alu_start;
    logic [2:0]  alu_op;
    logic        alu_rmw;
    logic [7:0]  alu_operand;
    logic        instruction_done;
    logic        branch_taken;
    logic [15:0] pc_branch;
    logic        exec_error;
    logic        busy;

    modport master (
        output instruction_ready, opcode, op_addr, imm, pc, acc, flags,
        output data_in, alu_done, alu_result,
        input  mem_addr, mem_we, mem_wdata, alu_start, alu_op, alu_rmw,
        input  alu_operand, instruction_done, branch_taken, pc_branch,
        input  exec_error, busy
    );

    modport slave (
        input  instruction_ready, opcode, op_addr, imm, pc, acc, flags,
        input  data_in, alu_done, alu_result,
        output mem_addr, mem_we, mem_wdata, alu_start, alu_op, alu_rmw,
        output alu_operand, instruction_done, branch_taken, pc_branch,
        output exec_error, busy
    );
endinterface

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: operand read, ALU handshake, writeback, branches.
// Every output is a register updated on phi1; busy decodes the state register.
module exec_sequencer #(
    parameter int ALU_TIMEOUT = 8
) (
    input logic            phi1,
    input logic            reset_n,
    exec_sequencer_if.slave bus
);
    localparam int CW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_ALU, S_WRITE, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        C_BRANCH, C_STORE, C_IMM, C_LOAD, C_RMW_MEM, C_RMW_ACC, C_NOP
    } cls_t;

    state_t        state;
    cls_t          cls;
    logic          ready_d;
    logic [2:0]    aaa_q;
    logic          rmw_q;
    logic          rmw_mem_q;
    logic [15:0]   addr_q;
    logic [CW-1:0] alu_cnt;
    logic [1:0]    cc;
    logic [2:0]    aaa;
    logic [2:0]    bbb;
    logic          flag_bit;
    logic [15:0]   target;
    logic          accept;
    logic          unused_flags;

    assign cc     = bus.opcode[1:0];
    assign bbb    = bus.opcode[4:2];
    assign aaa    = bus.opcode[7:5];
    assign target = bus.pc + {{8{bus.imm[7]}}, bus.imm};
    assign accept = bus.instruction_ready && !ready_d;
    assign unused_flags = ^bus.flags[5:2];
    assign bus.busy = (state != S_IDLE);

    always_comb begin
        flag_bit = 1'b0;
        unique case (bus.opcode[7:6])
            2'b00: flag_bit = bus.flags[7];
            2'b01: flag_bit = bus.flags[6];
            2'b10: flag_bit = bus.flags[0];
            2'b11: flag_bit = bus.flags[1];
        endcase
    end

    always_comb begin
        cls = C_NOP;
        unique case (1'b1)
            bus.opcode[4:0] == 5'b10000:
                cls = C_BRANCH;
            cc == 2'b01 && aaa == 3'b100:
                cls = C_STORE;
            cc == 2'b01 && aaa != 3'b100 && bbb == 3'b010:
                cls = C_IMM;
            cc == 2'b01 && aaa != 3'b100 && bbb != 3'b010:
                cls = C_LOAD;
            cc == 2'b10 && !aaa[2] && bbb[0]:
                cls = C_RMW_MEM;
            cc == 2'b10 && !aaa[2] && bbb == 3'b010:
                cls = C_RMW_ACC;
            default:
                cls = C_NOP;
        endcase
    end

    always_ff @(posedge phi1 or negedge reset_n) begin
        if (!reset_n) begin
            state                <= S_IDLE;
            ready_d              <= 1'b1;
            aaa_q                <= '0;
            rmw_q                <= 1'b0;
            rmw_mem_q            <= 1'b0;
            addr_q               <= '0;
            alu_cnt              <= '0;
            bus.mem_addr         <= '0;
            bus.mem_we           <= 1'b0;
            bus.mem_wdata        <= '0;
            bus.alu_start        <= 1'b0;
            bus.alu_op           <= '0;
            bus.alu_rmw          <= 1'b0;
            bus.alu_operand      <= '0;
            bus.instruction_done <= 1'b0;
            bus.branch_taken     <= 1'b0;
            bus.pc_branch        <= '0;
            bus.exec_error       <= 1'b0;
        end else begin
            ready_d <= bus.instruction_ready;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        aaa_q          <= aaa;
                        rmw_q          <= (cc == 2'b10);
                        rmw_mem_q      <= (cls == C_RMW_MEM);
                        addr_q         <= bus.op_addr;
                        bus.exec_error <= 1'b0;
                        unique case (cls)
                            C_BRANCH: begin
                                state                <= S_DONE;
                                bus.instruction_done <= 1'b1;
                                bus.branch_taken     <= (flag_bit == bus.opcode[5]);
                                bus.pc_branch        <= target;
                            end
                            C_STORE: begin
                                state         <= S_WRITE;
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= bus.op_addr;
                                bus.mem_wdata <= bus.acc;
                            end
                            C_IMM, C_RMW_ACC: begin
                                state           <= S_ALU;
                                alu_cnt         <= CW'(1);
                                bus.alu_start   <= 1'b1;
                                bus.alu_op      <= aaa;
                                bus.alu_rmw     <= (cls == C_RMW_ACC);
                                bus.alu_operand <= (cls == C_IMM) ? bus.imm : bus.acc;
                            end
                            C_LOAD, C_RMW_MEM: begin
                                state        <= S_READ;
                                bus.mem_addr <= bus.op_addr;
                            end
                            default: begin
                                state                <= S_DONE;
                                bus.instruction_done <= 1'b1;
                            end
                        endcase
                    end
                end
                S_READ: begin
                    state           <= S_ALU;
                    alu_cnt         <= CW'(1);
                    bus.mem_addr    <= '0;
                    bus.alu_start   <= 1'b1;
                    bus.alu_op      <= aaa_q;
                    bus.alu_rmw     <= rmw_q;
                    bus.alu_operand <= bus.data_in;
                end
                S_ALU: begin
                    bus.alu_start <= 1'b0;
                    if (bus.alu_done || alu_cnt == CW'(ALU_TIMEOUT)) begin
                        bus.alu_op      <= '0;
                        bus.alu_rmw     <= 1'b0;
                        bus.alu_operand <= '0;
                        if (bus.alu_done && rmw_mem_q) begin
                            state         <= S_WRITE;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= addr_q;
                            bus.mem_wdata <= bus.alu_result;
                        end else begin
                            state                <= S_DONE;
                            bus.instruction_done <= 1'b1;
                            bus.exec_error       <= !bus.alu_done;
                        end
                    end else begin
                        alu_cnt <= alu_cnt + CW'(1);
                    end
                end
                S_WRITE: begin
                    state                <= S_DONE;
                    bus.mem_we           <= 1'b0;
                    bus.mem_addr         <= '0;
                    bus.mem_wdata        <= '0;
                    bus.instruction_done <= 1'b1;
                end
                S_DONE: begin
                    state                <= S_IDLE;
                    bus.instruction_done <= 1'b0;
                    bus.branch_taken     <= 1'b0;
                    bus.pc_branch        <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: class paths, branches, timeout, reset.
// Inputs change #1 after posedge; outputs are sampled there too.
module tb_exec_sequencer;
    logic phi1;
    logic reset_n;
    int   checks;
    int   errors;

    exec_sequencer_if bus ();

    exec_sequencer #(.ALU_TIMEOUT(8)) dut (
        .phi1    (phi1),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial phi1 = 1'b0;
    always #5 phi1 = ~phi1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge phi1);
        #1;
    endtask

    // Drop ready for a cycle, then present the operands with a rising edge.
    task automatic issue(input logic [7:0] op, input logic [15:0] addr,
                         input logic [7:0] im, input logic [15:0] pcv,
                         input logic [7:0] ac, input logic [7:0] fl);
        bus.instruction_ready = 1'b0;
        tick();
        bus.opcode  = op;
        bus.op_addr = addr;
        bus.imm     = im;
        bus.pc      = pcv;
        bus.acc     = ac;
        bus.flags   = fl;
        bus.instruction_ready = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        bus.instruction_ready = 1'b1;
        bus.opcode = '0; bus.op_addr = '0; bus.imm = '0; bus.pc = '0;
        bus.acc = '0; bus.flags = '0; bus.data_in = '0;
        bus.alu_done = 1'b0; bus.alu_result = '0;
        repeat (3) tick();
        check("rst_done", bus.instruction_done, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_busy", bus.busy, 0);
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n += bus.instruction_done;
        end
        check("ready_held_done", n, 0);
        check("ready_held_busy", bus.busy, 0);

        // A9 immediate, ALU answers in its first cycle
        issue(8'hA9, 16'h0000, 8'h42, 16'h0000, 8'h00, 8'h00);
        check("a9_start", bus.alu_start, 1);
        check("a9_operand", bus.alu_operand, 8'h42);
        check("a9_op", bus.alu_op, 3'b101);
        check("a9_rmw", bus.alu_rmw, 0);
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        check("a9_done", bus.instruction_done, 1);
        check("a9_start_off", bus.alu_start, 0);
        tick();
        check("a9_done_off", bus.instruction_done, 0);
        check("a9_idle", bus.busy, 0);

        // 06 ASL zp: read, ALU, write back
        bus.data_in = 8'h81;
        issue(8'h06, 16'h0010, 8'h00, 16'h0000, 8'h00, 8'h00);
        check("06_raddr", bus.mem_addr, 16'h0010);
        check("06_rwe", bus.mem_we, 0);
        check("06_rstart", bus.alu_start, 0);
        tick();
        check("06_start", bus.alu_start, 1);
        check("06_rmw", bus.alu_rmw, 1);
        check("06_op", bus.alu_op, 3'b000);
        check("06_operand", bus.alu_operand, 8'h81);
        bus.alu_done = 1'b1;
        bus.alu_result = 8'h02;
        tick();
        bus.alu_done = 1'b0;
        check("06_we", bus.mem_we, 1);
        check("06_waddr", bus.mem_addr, 16'h0010);
        check("06_wdata", bus.mem_wdata, 8'h02);
        tick();
        check("06_done", bus.instruction_done, 1);
        check("06_we_off", bus.mem_we, 0);
        tick();

        // 8D store absolute
        issue(8'h8D, 16'h0200, 8'h00, 16'h0000, 8'h55, 8'h00);
        check("8d_we", bus.mem_we, 1);
        check("8d_addr", bus.mem_addr, 16'h0200);
        check("8d_wdata", bus.mem_wdata, 8'h55);
        check("8d_nostart", bus.alu_start, 0);
        tick();
        check("8d_done", bus.instruction_done, 1);
        check("8d_we_off", bus.mem_we, 0);
        tick();

        // BEQ variants and wrap-around targets
        issue(8'hF0, 16'h0000, 8'hFC, 16'h8002, 8'h00, 8'h02);
        check("f0z1_done", bus.instruction_done, 1);
        check("f0z1_taken", bus.branch_taken, 1);
        check("f0z1_target", bus.pc_branch, 16'h7FFE);
        tick();
        check("f0z1_taken_off", bus.branch_taken, 0);
        check("f0z1_target_off", bus.pc_branch, 0);
        issue(8'hF0, 16'h0000, 8'hFC, 16'h8002, 8'h00, 8'h00);
        check("f0z0_taken", bus.branch_taken, 0);
        tick();
        issue(8'hD0, 16'h0000, 8'h02, 16'hFFFF, 8'h00, 8'h00);
        check("d0_taken", bus.branch_taken, 1);
        check("d0_target", bus.pc_branch, 16'h0001);
        tick();
        // BCS with C=1 (flag select 10)
        issue(8'hB0, 16'h0000, 8'h10, 16'h1000, 8'h00, 8'h01);
        check("b0_taken", bus.branch_taken, 1);
        check("b0_target", bus.pc_branch, 16'h1010);
        tick();

        // 0A ASL A: ALU on accumulator, no memory write
        issue(8'h0A, 16'h0300, 8'h00, 16'h0000, 8'h7E, 8'h00);
        check("0a_operand", bus.alu_operand, 8'h7E);
        check("0a_rmw", bus.alu_rmw, 1);
        bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        check("0a_done", bus.instruction_done, 1);
        check("0a_nowe", bus.mem_we, 0);
        tick();

        // EA no-op completes immediately
        issue(8'hEA, 16'h0000, 8'h00, 16'h0000, 8'h00, 8'h00);
        check("ea_done", bus.instruction_done, 1);
        check("ea_nostart", bus.alu_start, 0);
        tick();

        // ALU never answers: timeout after 8 cycles; a ready edge meanwhile is ignored
        issue(8'h69, 16'h0000, 8'h11, 16'h0000, 8'h00, 8'h00);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            n += bus.mem_we + bus.instruction_done;
            if (i == 3) bus.instruction_ready = 1'b0;
            if (i == 5) bus.instruction_ready = 1'b1;
            if (i < 8) tick();
        end
        check("to_quiet", n, 0);
        check("to_busy", bus.busy, 1);
        tick();
        check("to_done", bus.instruction_done, 1);
        check("to_err", bus.exec_error, 1);
        check("to_nowe", bus.mem_we, 0);
        tick();
        check("to_idle", bus.busy, 0);
        check("to_err_held", bus.exec_error, 1);
        tick();
        check("to_no_reaccept", bus.busy, 0);

        // Reset in the middle of a read; the new accept also clears exec_error
        bus.data_in = 8'h33;
        issue(8'h0E, 16'h0444, 8'h00, 16'h0000, 8'h00, 8'h00);
        check("mid_err_clr", bus.exec_error, 0);
        check("mid_raddr", bus.mem_addr, 16'h0444);
        reset_n = 1'b0;
        #1;
        check("mid_addr0", bus.mem_addr, 0);
        check("mid_busy0", bus.busy, 0);
        check("mid_start0", bus.alu_start + bus.mem_we + bus.instruction_done, 0);
        tick();
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n += bus.mem_we + bus.instruction_done + bus.alu_start;
        end
        check("mid_quiet", n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
